regfile_wb_scheduler: RTL and testbench

//  Sequences the register file's single write port. Tracks in-flight

---
 rtl/regfile_wb_scheduler.sv | 109 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: busy-bit scoreboard for WAW stalls and RAW
// queries, round-robin ALU/LSU writeback arbitration, registered write stage.
module regfile_wb_scheduler #(
  parameter int unsigned REG_NUM    = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  rs1_hazard,
  output logic                  rs2_hazard,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  flush,
  output logic                  rf_wen,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_err
);

  localparam int unsigned IDX_W = $clog2(REG_NUM);

  typedef enum logic {RR_ALU, RR_LSU} rr_e;

  rr_e                   rr, rr_nxt;
  logic [REG_NUM-1:0]    busy, busy_nxt;
  logic                  flushed;
  logic                  grant_alu, grant_lsu, grant_any;
  logic [4:0]            g_rd;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  issue_fire;
  logic                  err_hit;

  assign rs1_hazard  = busy[rs1[IDX_W-1:0]] && (rs1 != 5'd0);
  assign rs2_hazard  = busy[rs2[IDX_W-1:0]] && (rs2 != 5'd0);
  assign issue_ready = !flush && ((issue_rd == 5'd0) || !busy[issue_rd[IDX_W-1:0]]);
  assign issue_fire  = issue_valid && issue_ready;
  assign alu_ready   = grant_alu;
  assign lsu_ready   = grant_lsu;

  always_comb begin
    grant_alu = alu_valid && (!lsu_valid || rr == RR_ALU);
    grant_lsu = lsu_valid && (!alu_valid || rr == RR_LSU);
    grant_any = grant_alu || grant_lsu;
    rr_nxt    = rr;
    g_rd      = '0;
    g_data    = '0;
    if (grant_alu) begin
      rr_nxt = RR_LSU;
      g_rd   = alu_rd;
      g_data = alu_data;
    end else if (grant_lsu) begin
      rr_nxt = RR_ALU;
      g_rd   = lsu_rd;
      g_data = lsu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) rr <= RR_ALU;
    else        rr <= rr_nxt;
  end

  // Clear comes from the committing write stage; a post-flush re-issue of the
  // same rd may coincide with it, so the set is applied last and wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_rd[IDX_W-1:0]] = 1'b0;
    if (issue_fire && issue_rd != 5'd0) busy_nxt[issue_rd[IDX_W-1:0]] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (flush) busy_nxt = '0;
  end

  // After a flush, orphaned writebacks target cleared regs; they are not errors
  // until the next issue re-establishes scoreboard tracking.
  assign err_hit = grant_any && (g_rd != 5'd0) && !busy[g_rd[IDX_W-1:0]] && !flushed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy     <= '0;
      flushed  <= 1'b0;
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (flush)           flushed <= 1'b1;
      else if (issue_fire) flushed <= 1'b0;
      rf_wen <= grant_any && (g_rd != 5'd0);
      if (grant_any) begin
        rf_rd    <= g_rd;
        rf_wdata <= g_data;
      end
      if (err_hit) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected regfile writes queued at
// grant time and compared one cycle later; comb outputs checked per step.
module tb_regfile_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        rs1_hazard, rs2_hazard;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        flush = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        wb_err;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit  pushed = 1'b0;
  int  passed = 0;
  int  failed = 0;
  int  total  = 0;

  regfile_wb_scheduler #(.REG_NUM(16), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .flush(flush), .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.wen  = 1'b1;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
    pushed = 1'b1;
  endtask

  // One clock: queue an idle expectation if nothing was granted, then compare
  // the write stage against the oldest expectation.
  task automatic tick();
    wr_t e;
    if (!pushed) exp_q.push_back('0);
    pushed = 1'b0;
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("rf_wen", 32'(rf_wen), 32'(e.wen));
    if (e.wen) begin
      chk("rf_rd", 32'(rf_rd), 32'(e.rd));
      chk("rf_wdata", rf_wdata, e.data);
    end
  endtask

  task automatic do_reset();
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    pushed = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    #1;
    chk("issue_ready", 32'(issue_ready), 1);
    tick();
    issue_valid = 1'b0;
  endtask

  // Present a writeback pair; ga/gl are the grants the bench expects.
  task automatic wb_step(input logic av, input logic [4:0] ard,
                         input logic lv, input logic [4:0] lrd,
                         input logic ga, input logic gl);
    alu_valid = av; alu_rd = ard; alu_data = 32'hA000_0000 | 32'(ard);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = 32'h5000_0000 | 32'(lrd);
    #1;
    chk("alu_ready", 32'(alu_ready), 32'(ga));
    chk("lsu_ready", 32'(lsu_ready), 32'(gl));
    if (ga)      expect_wr(ard, alu_data);
    else if (gl) expect_wr(lrd, lsu_data);
    tick();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b1;
    rs1 = 5'd5;
    #1;
    chk("rst_rf_rd", 32'(rf_rd), 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_wb_err", 32'(wb_err), 0);
    chk("rst_rs1_hazard", 32'(rs1_hazard), 0);

    // Single writeback: rd=5, 0xDEADBEEF
    issue(5'd5);
    issue_rd = 5'd5;
    #1;
    chk("hz5_set", 32'(rs1_hazard), 1);
    chk("waw5_stall", 32'(issue_ready), 0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    chk("alu5_ready", 32'(alu_ready), 1);
    chk("lsu5_ready", 32'(lsu_ready), 0);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("hz5_commit_cycle", 32'(rs1_hazard), 1);
    tick();
    #1;
    chk("hz5_cleared", 32'(rs1_hazard), 0);
    chk("issue5_free", 32'(issue_ready), 1);

    // Round robin with both requesters active
    do_reset();
    for (int i = 1; i <= 4; i++) issue(5'(i));
    wb_step(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
    wb_step(1'b1, 5'd3, 1'b1, 5'd2, 1'b0, 1'b1);
    wb_step(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    wb_step(1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1);
    tick();
    rs1 = 5'd1; rs2 = 5'd4;
    #1;
    chk("rr_hz1_clear", 32'(rs1_hazard), 0);
    chk("rr_hz4_clear", 32'(rs2_hazard), 0);
    chk("rr_no_err", 32'(wb_err), 0);

    // WAW stall on rd=7 and x0 issue
    issue(5'd7);
    issue_valid = 1'b1; issue_rd = 5'd7; rs2 = 5'd7;
    #1;
    chk("waw7_stall", 32'(issue_ready), 0);
    chk("hz7_rs2", 32'(rs2_hazard), 1);
    wb_step(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    chk("waw7_commit_cycle", 32'(issue_ready), 0);
    tick();
    #1;
    chk("waw7_release", 32'(issue_ready), 1);
    issue_rd = 5'd0; rs1 = 5'd0;
    #1;
    chk("x0_ready", 32'(issue_ready), 1);
    chk("x0_hazard", 32'(rs1_hazard), 0);
    tick();
    issue_valid = 1'b0;

    // Writeback to a non-busy register
    wb_step(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1);
    #1;
    chk("wb_err_set", 32'(wb_err), 1);
    tick();
    tick();
    chk("wb_err_sticky", 32'(wb_err), 1);

    // Flush with a concurrent ALU grant
    do_reset();
    #1;
    chk("wb_err_reset", 32'(wb_err), 0);
    issue(5'd3);
    issue(5'd4);
    flush = 1'b1; issue_rd = 5'd8;
    #1;
    chk("flush_blocks_issue", 32'(issue_ready), 0);
    wb_step(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0);
    flush = 1'b0;
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    chk("flush_hz3", 32'(rs1_hazard), 0);
    chk("flush_hz4", 32'(rs2_hazard), 0);
    chk("flush_no_err", 32'(wb_err), 0);
    chk("post_flush_ready", 32'(issue_ready), 1);
    wb_step(1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1);
    #1;
    chk("orphan_wb_no_err", 32'(wb_err), 0);
    issue(5'd6);
    wb_step(1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 1'b1);
    #1;
    chk("wb_err_rearmed", 32'(wb_err), 1);

    // Reset while a write is pending in the write stage
    issue(5'd2);
    issue(5'd13);
    wb_step(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd13; lsu_valid = 1'b1; lsu_rd = 5'd14;
    reset = 1'b0;
    exp_q.delete();
    pushed = 1'b0;
    tick();
    reset = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rs1 = 5'd2; rs2 = 5'd13;
    #1;
    chk("midrst_hz2", 32'(rs1_hazard), 0);
    chk("midrst_hz13", 32'(rs2_hazard), 0);
    chk("midrst_wb_err", 32'(wb_err), 0);
    wb_step(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
